wb_periph_regs: RTL and testbench

Wishbone B4 classic slave sitting directly downstream of the SPI-to-Wishbone bridge, on the same system clock.
- Holds the control register bank, a 256-word scratch RAM, sticky-interrupt logic driving the host interrupt line, and a 3-channel LED PWM generator feeding the RGB driver.
- Replaces the ad-hoc inline peripheral in the top level.

---
 rtl/wb_periph_pkg.sv | 30 +++
 rtl/led_pwm_gen.sv | 74 +++++++
 rtl/wb_periph_regs.sv | 186 ++++++++++++++++++
 tb/tb_wb_periph_regs.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_periph_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_periph_pkg
//  Description : Shared definitions for the Wishbone peripheral register
//                block: word-address map, event/PWM widths and the CTRL
//                register layout.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_periph_pkg;

    // Word addresses, low 9 bits (upper address bits must be zero)
    localparam logic [8:0] ADR_ID         = 9'h000;
    localparam logic [8:0] ADR_CTRL       = 9'h001;
    localparam logic [8:0] ADR_DUTY       = 9'h002;
    localparam logic [8:0] ADR_IRQ_STATUS = 9'h003;
    localparam logic [8:0] ADR_IRQ_MASK   = 9'h004;
    localparam logic [8:0] ADR_IRQ_FORCE  = 9'h005;
    localparam logic [8:0] ADR_SCRATCH    = 9'h006;
    localparam logic [8:0] RAM_BASE       = 9'h100;

    localparam int NUM_EVT = 8;
    localparam int PWM_W   = 8;

    typedef struct packed {
        logic       blink_en;
        logic [2:0] led_en;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/led_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_pwm_gen
//  Description : 3-channel LED PWM generator. A prescaler divides clk by
//                PWM_PRESCALE to step an 8-bit PWM counter; each channel is on
//                while the counter is below its duty value. A free-running
//                24-bit counter supplies the blink phase. Duty values are
//                shadowed and only adopted when the PWM counter wraps to 0.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                ctrl         - LED enables and blink enable
//                duty         - {blue, green, red} duty, 8 bits each
//                led_pwm      - registered PWM enables {blue, green, red}
//  Revision    : 1.0  initial release
// ============================================================================
module led_pwm_gen
    import wb_periph_pkg::*;
#(
    parameter int PWM_PRESCALE = 4,
    parameter int BLINK_BIT    = 22
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  ctrl_t                ctrl,
    input  logic [3*PWM_W-1:0]   duty,
    output logic [2:0]           led_pwm
);

    // A prescale of 1 still needs a 1-bit counter that simply stays at 0
    localparam int              PS_W    = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PWM_PRESCALE - 1);

    logic [PS_W-1:0]      r_presc;
    logic [PWM_W-1:0]     r_pwm_cnt;
    logic [23:0]          r_blink_cnt;
    logic [3*PWM_W-1:0]   r_duty_shadow;
    logic                 w_step;
    logic                 w_wrap;
    logic                 w_blink;
    logic [2:0]           w_led;

    assign w_step  = (r_presc == PS_LAST);
    assign w_wrap  = w_step && (r_pwm_cnt == {PWM_W{1'b1}});
    assign w_blink = r_blink_cnt[BLINK_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc       <= '0;
            r_pwm_cnt     <= '0;
            r_blink_cnt   <= '0;
            r_duty_shadow <= '0;
            led_pwm       <= '0;
        end else begin
            r_presc     <= w_step ? '0 : r_presc + 1'b1;
            r_blink_cnt <= r_blink_cnt + 24'd1;
            if (w_step) begin
                r_pwm_cnt <= r_pwm_cnt + 1'b1;
            end
            // New duty is adopted exactly as the counter returns to 0, so a
            // period is never cut short or stretched by a mid-period write.
            if (w_wrap) begin
                r_duty_shadow <= duty;
            end
            led_pwm <= w_led;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        assign w_led[c] = ctrl.led_en[c]
                        & (r_pwm_cnt < r_duty_shadow[c*PWM_W +: PWM_W])
                        & (~ctrl.blink_en | w_blink);
    end

endmodule
`default_nettype wire

// File: rtl/wb_periph_regs.sv
`default_nettype none
// ============================================================================
//  Module      : wb_periph_regs
//  Description : Wishbone B4 classic slave: ID/CTRL/DUTY/IRQ/SCRATCH
//                registers, 256-word scratch RAM, sticky interrupts driving
//                irq_o, and a 3-channel LED PWM generator.
//  Ports       : clk, rst_n              - clock, async active-low reset
//                i_wb_cyc/stb/we/adr/dat - Wishbone request
//                o_wb_ack, o_wb_dat      - Wishbone response
//                o_wb_err                - error response (WB_PERIPH_ERR_EN)
//                evt_i                   - 1-clk event pulses, one per source
//                irq_o                   - level interrupt to host
//                led_pwm_o               - PWM enables {blue, green, red}
//  Options     : define WB_PERIPH_ERR_EN to add o_wb_err; unmapped accesses
//                then get err instead of ack.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_periph_regs
    import wb_periph_pkg::*;
#(
    parameter logic [31:0] ID_VALUE     = 32'h5350_0001,
    parameter int          PWM_PRESCALE = 4,
    parameter int          BLINK_BIT    = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [25:0]         i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    output logic                o_wb_ack,
    output logic [31:0]         o_wb_dat,
`ifdef WB_PERIPH_ERR_EN
    output logic                o_wb_err,
`endif
    input  logic [NUM_EVT-1:0]  evt_i,
    output logic                irq_o,
    output logic [2:0]          led_pwm_o
);

    logic                 w_req;
    logic                 w_busy;
    logic                 w_take;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_hi_zero;
    logic                 w_ram_hit;
    logic                 w_reg_hit;
    logic                 w_mapped;
    logic [31:0]          w_reg_rdata;
    logic [NUM_EVT-1:0]   w_w1c;
    logic [NUM_EVT-1:0]   w_force;
    logic [7:0]           w_ram_idx;

    ctrl_t                r_ctrl;
    logic [23:0]          r_duty;
    logic [NUM_EVT-1:0]   r_status;
    logic [NUM_EVT-1:0]   r_mask;
    logic [31:0]          r_scratch;
    logic [31:0]          r_reg_q;
    logic                 r_rd_ram;
    logic [31:0]          r_ram_q;
    logic [31:0]          r_ram [256];

    // ------------------------------------------------------------------
    // Handshake: a request is accepted only when no response is
    // currently showing, giving one response per two cycles on a held
    // strobe. Writes commit on the same edge that raises the response.
    // ------------------------------------------------------------------
    assign w_req = i_wb_cyc & i_wb_stb;
`ifdef WB_PERIPH_ERR_EN
    assign w_busy = o_wb_ack | o_wb_err;
`else
    assign w_busy = o_wb_ack;
`endif
    assign w_take = w_req & ~w_busy;
    assign w_wr   = w_take & i_wb_we;
    assign w_rd   = w_take & ~i_wb_we;

    // ------------------------------------------------------------------
    // Address decode and register read mux
    // ------------------------------------------------------------------
    assign w_hi_zero = (i_wb_adr[25:9] == '0);
    assign w_ram_hit = w_hi_zero & i_wb_adr[8];
    assign w_ram_idx = i_wb_adr[7:0];
    assign w_mapped  = w_ram_hit | w_reg_hit;

    always_comb begin
        w_reg_rdata = '0;
        w_reg_hit   = 1'b0;
        if (w_hi_zero) begin
            w_reg_hit = 1'b1;
            case (i_wb_adr[8:0])
                ADR_ID:         w_reg_rdata = ID_VALUE;
                ADR_CTRL:       w_reg_rdata = {28'd0, r_ctrl};
                ADR_DUTY:       w_reg_rdata = {8'd0, r_duty};
                ADR_IRQ_STATUS: w_reg_rdata = {{(32-NUM_EVT){1'b0}}, r_status};
                ADR_IRQ_MASK:   w_reg_rdata = {{(32-NUM_EVT){1'b0}}, r_mask};
                ADR_IRQ_FORCE:  w_reg_rdata = '0;
                ADR_SCRATCH:    w_reg_rdata = r_scratch;
                default:        w_reg_hit   = 1'b0;
            endcase
        end
    end

    assign w_w1c   = (w_wr && w_reg_hit && i_wb_adr[8:0] == ADR_IRQ_STATUS)
                   ? i_wb_dat[NUM_EVT-1:0] : '0;
    assign w_force = (w_wr && w_reg_hit && i_wb_adr[8:0] == ADR_IRQ_FORCE)
                   ? i_wb_dat[NUM_EVT-1:0] : '0;

    // ------------------------------------------------------------------
    // Bus response, control registers, interrupts
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wb_ack  <= 1'b0;
`ifdef WB_PERIPH_ERR_EN
            o_wb_err  <= 1'b0;
`endif
            r_ctrl    <= '0;
            r_duty    <= '0;
            r_status  <= '0;
            r_mask    <= '0;
            r_scratch <= '0;
            r_reg_q   <= '0;
            r_rd_ram  <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
`ifdef WB_PERIPH_ERR_EN
            o_wb_ack <= w_take & w_mapped;
            o_wb_err <= w_take & ~w_mapped;
`else
            o_wb_ack <= w_take;
`endif
            if (w_rd) begin
                r_rd_ram <= w_ram_hit;
                r_reg_q  <= w_reg_rdata;
            end
            if (w_wr && w_reg_hit) begin
                case (i_wb_adr[8:0])
                    ADR_CTRL:     r_ctrl    <= ctrl_t'(i_wb_dat[3:0]);
                    ADR_DUTY:     r_duty    <= i_wb_dat[23:0];
                    ADR_IRQ_MASK: r_mask    <= i_wb_dat[NUM_EVT-1:0];
                    ADR_SCRATCH:  r_scratch <= i_wb_dat;
                    default:      ;
                endcase
            end
            // Sets are OR-ed in after the clear so a same-cycle event wins
            r_status <= (r_status & ~w_w1c) | evt_i | w_force;
            irq_o    <= |(r_status & r_mask);
        end
    end

    // ------------------------------------------------------------------
    // Scratch RAM: synchronous read, no reset on contents or read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr && w_ram_hit) begin
            r_ram[w_ram_idx] <= i_wb_dat;
        end
        if (w_rd && w_ram_hit) begin
            r_ram_q <= r_ram[w_ram_idx];
        end
    end

    // Both sources are registers that only change on a read, so the last
    // read value is held; after reset r_rd_ram=0 and r_reg_q=0.
    assign o_wb_dat = r_rd_ram ? r_ram_q : r_reg_q;

    // ------------------------------------------------------------------
    // LED PWM
    // ------------------------------------------------------------------
    led_pwm_gen #(
        .PWM_PRESCALE (PWM_PRESCALE),
        .BLINK_BIT    (BLINK_BIT)
    ) u_led_pwm_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .ctrl    (r_ctrl),
        .duty    (r_duty),
        .led_pwm (led_pwm_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_wb_periph_regs.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_periph_regs
//  Description : Self-checking bench for wb_periph_regs (PWM_PRESCALE=1,
//                BLINK_BIT=6 so PWM and blink phases line up in a short run).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_periph_regs;

`ifdef WB_PERIPH_ERR_EN
    localparam bit ERR_MODE = 1'b1;
`else
    localparam bit ERR_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [25:0] adr = '0;
    logic [31:0] wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        err;
    logic [7:0]  evt = '0;
    logic        irq;
    logic [2:0]  led;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_periph_regs #(
        .ID_VALUE     (32'h5350_0001),
        .PWM_PRESCALE (1),
        .BLINK_BIT    (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wb_cyc  (cyc),
        .i_wb_stb  (stb),
        .i_wb_we   (we),
        .i_wb_adr  (adr),
        .i_wb_dat  (wdat),
        .o_wb_ack  (ack),
        .o_wb_dat  (rdat),
`ifdef WB_PERIPH_ERR_EN
        .o_wb_err  (err),
`endif
        .evt_i     (evt),
        .irq_o     (irq),
        .led_pwm_o (led)
    );
`ifndef WB_PERIPH_ERR_EN
    assign err = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        we;
        logic [25:0] adr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        unmapped;
    } vec_t;

    typedef struct {
        string       name;
        logic        is_rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after one idle cycle.
    task automatic wb_xfer(input string name, input logic w, input logic [25:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd,
                           input logic unmapped);
        exp_t e;
        int   lat;
        logic got;
        e.name  = name;
        e.is_rd = !w;
        e.data  = exp_rd;
        e.err   = ERR_MODE && unmapped;
        sb.push_back(e);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 4) begin
            tick(1);
            lat++;
            got = ack | err;
        end
        e = sb.pop_front();
        if (!got) begin
            check({e.name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({e.name, " latency"}, 32'(lat), 32'd1);
            check({e.name, " ack/err"}, {30'd0, ack, err}, {30'd0, ~e.err, e.err});
            if (e.is_rd) check({e.name, " data"}, rdat, e.data);
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick(1);
    endtask

    task automatic count_led(input int n, output int r, output int g, output int b);
        r = 0; g = 0; b = 0;
        repeat (n) begin
            tick(1);
            r += int'(led[0]);
            g += int'(led[1]);
            b += int'(led[2]);
        end
    endtask

    vec_t vecs[$];

    initial begin : main
        int   r, g, b, k, held_acks;
        logic prev;

        vecs = '{
            '{"rd ID",        1'b0, 26'h000, 32'h0,        32'h5350_0001, 1'b0},
            '{"rd CTRL rst",  1'b0, 26'h001, 32'h0,        32'h0,         1'b0},
            '{"wr SCRATCH",   1'b1, 26'h006, 32'hCAFEF00D, 32'h0,         1'b0},
            '{"wr RAM 1A5",   1'b1, 26'h1A5, 32'h12345678, 32'h0,         1'b0},
            '{"rd SCRATCH",   1'b0, 26'h006, 32'h0,        32'hCAFEF00D,  1'b0},
            '{"rd RAM 1A5",   1'b0, 26'h1A5, 32'h0,        32'h12345678,  1'b0},
            '{"rd unmap 0A0", 1'b0, 26'h0A0, 32'h0,        32'h0,         1'b1},
            '{"wr DUTY ones", 1'b1, 26'h002, 32'hFFFFFFFF, 32'h0,         1'b0},
            '{"rd DUTY",      1'b0, 26'h002, 32'h0,        32'h00FFFFFF,  1'b0},
            '{"wr RAM 100",   1'b1, 26'h100, 32'hA5A5A5A5, 32'h0,         1'b0},
            '{"rd RAM 100",   1'b0, 26'h100, 32'h0,        32'hA5A5A5A5,  1'b0},
            '{"wr hi 3A5",    1'b1, 26'h3A5, 32'hDEADBEEF, 32'h0,         1'b1},
            '{"rd RAM 1A5 b", 1'b0, 26'h1A5, 32'h0,        32'h12345678,  1'b0},
            '{"rd hi 200",    1'b0, 26'h200, 32'h0,        32'h0,         1'b1},
            '{"wr MASK",      1'b1, 26'h004, 32'h000001FF, 32'h0,         1'b0},
            '{"rd MASK",      1'b0, 26'h004, 32'h0,        32'h000000FF,  1'b0},
            '{"wr CTRL",      1'b1, 26'h001, 32'hFFFFFFFF, 32'h0,         1'b0},
            '{"rd CTRL",      1'b0, 26'h001, 32'h0,        32'h0000000F,  1'b0},
            '{"rd FORCE",     1'b0, 26'h005, 32'h0,        32'h0,         1'b0},
            '{"wr ID",        1'b1, 26'h000, 32'h0000DEAD, 32'h0,         1'b0},
            '{"rd ID again",  1'b0, 26'h000, 32'h0,        32'h5350_0001, 1'b0},
            '{"wr unmap 007", 1'b1, 26'h007, 32'h11111111, 32'h0,         1'b1},
            '{"rd unmap 007", 1'b0, 26'h007, 32'h0,        32'h0,         1'b1},
            '{"clr CTRL",     1'b1, 26'h001, 32'h0,        32'h0,         1'b0},
            '{"clr MASK",     1'b1, 26'h004, 32'h0,        32'h0,         1'b0}
        };

        // ---------------- reset values ----------------
        #22;
        check("rst ack", {31'd0, ack}, 32'd0);
        check("rst dat", rdat, 32'd0);
        check("rst irq", {31'd0, irq}, 32'd0);
        check("rst led", {29'd0, led}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(2);

        // ---------------- table-driven register/RAM vectors ----------------
        foreach (vecs[i]) begin
            wb_xfer(vecs[i].name, vecs[i].we, vecs[i].adr, vecs[i].wd,
                    vecs[i].exp_rd, vecs[i].unmapped);
        end

        // ---------------- request dropped before ack ----------------
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 26'h006; wdat = 32'h0BAD0BAD;
        #3;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick(1);
        check("dropped no ack", {31'd0, ack}, 32'd0);
        tick(1);
        wb_xfer("rd SCRATCH after drop", 1'b0, 26'h006, 32'h0, 32'hCAFEF00D, 1'b0);

        // ---------------- held strobe: one ack per two cycles ----------------
        held_acks = 0;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 26'h000;
        repeat (6) begin
            tick(1);
            held_acks += int'(ack);
        end
        cyc = 1'b0; stb = 1'b0;
        tick(1);
        check("held stb acks", 32'(held_acks), 32'd3);

        // ---------------- interrupts ----------------
        wb_xfer("wr MASK 05", 1'b1, 26'h004, 32'h05, 32'h0, 1'b0);
        evt = 8'h04;
        tick(1);
        evt = 8'h00;
        check("irq +1", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq +2", {31'd0, irq}, 32'd1);
        // W1C together with a new event on the same bit: set must win
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 26'h003; wdat = 32'h04; evt = 8'h04;
        tick(1);
        evt = 8'h00;
        check("w1c+evt ack", {31'd0, ack}, 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick(1);
        wb_xfer("rd STATUS set wins", 1'b0, 26'h003, 32'h0, 32'h04, 1'b0);
        check("irq still high", {31'd0, irq}, 32'd1);
        wb_xfer("w1c STATUS", 1'b1, 26'h003, 32'h04, 32'h0, 1'b0);
        check("irq low after w1c", {31'd0, irq}, 32'd0);
        evt = 8'h02;          // masked source: status sets, irq stays low
        tick(1);
        evt = 8'h00;
        tick(2);
        check("masked evt irq", {31'd0, irq}, 32'd0);
        wb_xfer("rd STATUS masked", 1'b0, 26'h003, 32'h0, 32'h02, 1'b0);
        wb_xfer("force bit0", 1'b1, 26'h005, 32'h01, 32'h0, 1'b0);
        check("irq from force", {31'd0, irq}, 32'd1);
        wb_xfer("rd STATUS forced", 1'b0, 26'h003, 32'h0, 32'h03, 1'b0);
        wb_xfer("w1c all", 1'b1, 26'h003, 32'hFF, 32'h0, 1'b0);
        check("irq cleared", {31'd0, irq}, 32'd0);

        // ---------------- PWM duty counts ----------------
        wb_xfer("wr CTRL 7", 1'b1, 26'h001, 32'h7, 32'h0, 1'b0);
        wb_xfer("wr DUTY", 1'b1, 26'h002, 32'h00FF8040, 32'h0, 1'b0);
        tick(300);
        count_led(256, r, g, b);
        check("pwm red 64", 32'(r), 32'd64);
        check("pwm green 128", 32'(g), 32'd128);
        check("pwm blue 255", 32'(b), 32'd255);

        // ---------------- duty change mid-period ----------------
        prev = led[0];
        k = 0;
        while (!(prev && !led[0]) && k < 600) begin
            prev = led[0];
            tick(1);
            k++;
        end
        check("red fall seen", {31'd0, (k < 600)}, 32'd1);
        wb_xfer("wr DUTY mid", 1'b1, 26'h002, 32'h00FF80C0, 32'h0, 1'b0);
        count_led(150, r, g, b);
        check("old duty persists", 32'(r), 32'd0);
        k = 0;
        while (!led[0] && k < 300) begin
            tick(1);
            k++;
        end
        check("red rise seen", {31'd0, (k < 300)}, 32'd1);
        r = 0;
        while (led[0] && r < 300) begin
            r++;
            tick(1);
        end
        check("new duty run", 32'(r), 32'd192);

        // ---------------- blink gating, duty 0 ----------------
        wb_xfer("wr CTRL blink", 1'b1, 26'h001, 32'hF, 32'h0, 1'b0);
        wb_xfer("wr DUTY blink", 1'b1, 26'h002, 32'h000000FF, 32'h0, 1'b0);
        tick(300);
        count_led(256, r, g, b);
        check("blink red 127", 32'(r), 32'd127);
        check("duty0 green", 32'(g), 32'd0);
        check("duty0 blue", 32'(b), 32'd0);

        // ---------------- async reset mid-read / mid-PWM ----------------
        wb_xfer("wr CTRL 7 b", 1'b1, 26'h001, 32'h7, 32'h0, 1'b0);
        wb_xfer("wr MASK 1", 1'b1, 26'h004, 32'h1, 32'h0, 1'b0);
        wb_xfer("force 1", 1'b1, 26'h005, 32'h1, 32'h0, 1'b0);
        check("irq before rst", {31'd0, irq}, 32'd1);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 26'h000;
        tick(1);
        check("ack before rst", {31'd0, ack}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst ack", {31'd0, ack}, 32'd0);
        check("async rst irq", {31'd0, irq}, 32'd0);
        check("async rst led", {29'd0, led}, 32'd0);
        check("async rst dat", rdat, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        wb_xfer("rd CTRL post", 1'b0, 26'h001, 32'h0, 32'h0, 1'b0);
        wb_xfer("rd DUTY post", 1'b0, 26'h002, 32'h0, 32'h0, 1'b0);
        wb_xfer("rd MASK post", 1'b0, 26'h004, 32'h0, 32'h0, 1'b0);
        wb_xfer("rd STATUS post", 1'b0, 26'h003, 32'h0, 32'h0, 1'b0);
        wb_xfer("rd SCRATCH post", 1'b0, 26'h006, 32'h0, 32'h0, 1'b0);
        check("irq post rst", {31'd0, irq}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
